raster_cmd_scheduler: RTL and testbench
=======================================

# raster_cmd_scheduler

Two-port command scheduler in front of the 8x8 rasterizer. It accepts draw commands from two requesters (host port A, sprite/engine port B) over valid/ready handshakes and arbitrates between them round-robin. Accepted commands are buffered in a small FIFO and issued to the rasterizer one at a time. Each command is paced by the rasterizer's frame_sync pulse and its fixed 64-cycle pixel readout, and a watchdog flags a rasterizer that never answers.

## Interface
- DEPTH, 4, command FIFO entries (power of two, 2..16)
- SYNC_TIMEOUT, 8, maximum consecutive cycles without frame_sync after an issue before error
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- a_valid / b_valid  input  1  requester has a command
- a_ready / b_ready  output  1  command accepted this cycle when valid is also high
- a_cmd / b_cmd  input  2  00 NOP, 01 pixel or clear, 10 line, 11 rect
- a_args / b_args  input  18  packed {x1,y1,x2,y2,width,height}, 3 bits each, x1 in [17:15]
- ras_cmd  output  2  to rasterizer cmd; non-zero for exactly one cycle per command
- ras_args  output  18  to rasterizer coordinates, same packing, held until next issue
- frame_sync  input  1  from rasterizer
- busy  output  1  FSM not in IDLE or FIFO not empty
- done  output  1  one-cycle pulse when a command's readout window completes
- err  output  1  sticky watchdog error, cleared only by reset
- issued  output  8  count of commands issued, wraps 255→0

## Operation
- Arbiter:
  - a_ready/b_ready are combinational.
  - Grant at most one port per cycle, and only when the FIFO is not full.
  - If one port is valid, grant it. If both are valid, grant the port named by the rr bit.
  - rr flips to the other port after every grant.
  - rr resets to A.
- A granted command with cmd==00 is handshaken (ready=1) and discarded. It is not enqueued.
- FIFO:
  - DEPTH entries of 20 bits, pointers one bit wider than the address.
  - Push and pop in the same cycle are both honoured.
  - When full, both ready outputs are low and no push occurs.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head, register ras_cmd and ras_args, increment issued, go to ISSUE.
  - ISSUE: ras_cmd is visible for this one cycle. On the next edge, ras_cmd goes to 00, timer is set to 0, and the FSM goes to WAIT.
  - WAIT: if frame_sync=1, load drain=63 and go to DRAIN. Otherwise increment timer; when timer reaches SYNC_TIMEOUT-1, set err and go to IDLE.
  - DRAIN: decrement drain each cycle. When drain==0, pulse done and go to IDLE.
- Once err is set, the scheduler keeps operating normally.
- Reset values: ras_cmd=00, ras_args=0, done=0, err=0, busy=0, issued=0, FIFO empty, state IDLE.
- Reset mid-operation aborts everything immediately and discards the FIFO contents. The rasterizer shares rst_n.

## Timing
- Accept-to-issue latency:
  - A command accepted at edge T with the FSM idle and the FIFO empty is popped at T+1.
  - ras_cmd is high during cycle T+1..T+2 and is sampled by the rasterizer at edge T+2.
- Let E0 be the edge at which the rasterizer samples ras_cmd. Then:
  - frame_sync is seen at E2.
  - DRAIN runs from E2 through E66.
  - done is high for one cycle after E66.
  - The next pop happens at E67, and the next rasterizer sample at E68.
- Issue-to-issue period with a full queue: 68 cycles.
- ras_cmd never goes non-zero while the FSM is in WAIT or DRAIN. Commands are never issued back-to-back without an intervening readout.
- A frame_sync seen outside WAIT is ignored.
- issued increments in the same cycle as the pop.

## Test plan
- Single command:
  - Stimulus: a_valid with cmd=01, args x1=3, y1=2 (a_args=0x1A000 when the remaining fields are 0), FIFO empty, with a rasterizer model attached.
  - Required: ras_cmd=01 for exactly 1 cycle, sampled 2 edges after acceptance; ras_args=0x1A000; frame_sync 2 cycles later; done pulse 64 cycles after frame_sync; issued=1; busy low afterwards.
- Round-robin:
  - Stimulus: a_valid and b_valid held for 6 cycles with distinct args.
  - Required: grants alternate A,B,A,B; the FIFO fills at 4 and both ready outputs drop; issue order matches grant order; the issue spacing is 68 cycles.
- NOP drop:
  - Stimulus: b_cmd=00, b_valid=1.
  - Required: b_ready=1, FIFO count unchanged, ras_cmd stays 00, issued=0.
- Watchdog:
  - Stimulus: frame_sync tied to 0, one command issued.
  - Required: err rises SYNC_TIMEOUT cycles after WAIT entry; FSM returns to IDLE; the next queued command still issues; err stays 1.
- Simultaneous push/pop:
  - Stimulus: FIFO holding 4 entries, FSM in DRAIN reaching 0, a_valid=1.
  - Required: on the pop cycle a_ready is still 0 (FIFO full); it rises the following cycle and the FIFO occupancy returns to 4; no entry is lost or duplicated.
- Reset mid-DRAIN:
  - Stimulus: 3 commands queued, rst_n asserted for 2 cycles mid-DRAIN.
  - Required: all outputs return to reset values asynchronously; no issue occurs after release without new requests.

Source files
------------

// File: rtl/raster_cmd_scheduler.sv
// raster_cmd_scheduler
// Two-port command scheduler in front of the 8x8 rasterizer. It round-robin
// arbitrates draw commands from requester A (host) and requester B
// (sprite/engine) into a small FIFO. It then issues them one at a time, each
// paced by frame_sync and the fixed 64-cycle pixel readout. A watchdog flags a
// rasterizer that never answers.
//
// Parameters
//   DEPTH         command FIFO entries (power of two, 2..16)
//   SYNC_TIMEOUT  cycles allowed in WAIT without frame_sync before err
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   a_valid/a_ready     requester A handshake; a_cmd[1:0], a_args[17:0]
//   b_valid/b_ready     requester B handshake; b_cmd[1:0], b_args[17:0]
//   ras_cmd[1:0]        rasterizer command, non-zero for one cycle per issue
//   ras_args[17:0]      rasterizer coordinates {x1,y1,x2,y2,w,h}, held
//   frame_sync          rasterizer frame sync pulse
//   busy                FSM active or FIFO non-empty
//   done                one-cycle pulse at end of a readout window
//   err                 sticky watchdog error
//   issued[7:0]         wrapping count of issued commands
module raster_cmd_scheduler #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned SYNC_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [1:0]  a_cmd,
  input  logic [17:0] a_args,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [1:0]  b_cmd,
  input  logic [17:0] b_args,
  output logic [1:0]  ras_cmd,
  output logic [17:0] ras_args,
  input  logic        frame_sync,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  issued
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW = $clog2(SYNC_TIMEOUT) + 1;
  localparam logic [TW-1:0] TimerLast = TW'(SYNC_TIMEOUT - 1);
  localparam logic [TW-1:0] TimerOne  = TW'(1);
  localparam logic [AW:0]   PtrOne    = (AW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDrain} state_e;

  state_e state_q, state_d;

  // Arbiter
  logic        rr_q;  // 0: A wins a tie, 1: B wins a tie
  logic        fifo_full, fifo_empty;
  logic        gnt_a, gnt_b, gnt_any;
  logic [1:0]  gnt_cmd;
  logic [17:0] gnt_args;
  logic        push, pop;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!fifo_full) begin
      if (a_valid && b_valid) begin
        gnt_a = ~rr_q;
        gnt_b = rr_q;
      end else begin
        gnt_a = a_valid;
        gnt_b = b_valid;
      end
    end
  end

  assign a_ready  = gnt_a;
  assign b_ready  = gnt_b;
  assign gnt_any  = gnt_a | gnt_b;
  assign gnt_cmd  = gnt_b ? b_cmd : a_cmd;
  assign gnt_args = gnt_b ? b_args : a_args;
  // NOPs complete the handshake but never reach the FIFO.
  assign push     = gnt_any && (gnt_cmd != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else if (gnt_any) begin
      rr_q <= ~rr_q;
    end
  end

  // Command FIFO: {cmd, args}, pointers carry an extra wrap bit.
  logic [19:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [19:0] head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {gnt_cmd, gnt_args};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Issue FSM
  logic [1:0]    ras_cmd_q, ras_cmd_d;
  logic [17:0]   ras_args_q, ras_args_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [5:0]    drain_q, drain_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    issued_q, issued_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait: begin
        if (frame_sync) begin
          state_d = StDrain;
        end else if (timer_q == TimerLast) begin
          state_d = StIdle;
        end
      end
      StDrain: if (drain_q == 6'd0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign pop = (state_q == StIdle) && !fifo_empty;

  always_comb begin
    ras_cmd_d  = ras_cmd_q;
    ras_args_d = ras_args_q;
    timer_d    = timer_q;
    drain_d    = drain_q;
    done_d     = 1'b0;
    err_d      = err_q;
    issued_d   = issued_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          ras_cmd_d  = head[19:18];
          ras_args_d = head[17:0];
          issued_d   = issued_q + 8'd1;
        end
      end
      StIssue: begin
        ras_cmd_d = 2'b00;
        timer_d   = '0;
      end
      StWait: begin
        if (frame_sync) begin
          drain_d = 6'd63;
        end else if (timer_q == TimerLast) begin
          err_d = 1'b1;
        end else begin
          timer_d = timer_q + TimerOne;
        end
      end
      StDrain: begin
        if (drain_q == 6'd0) begin
          done_d = 1'b1;
        end else begin
          drain_d = drain_q - 6'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_cmd_q  <= 2'b00;
      ras_args_q <= '0;
      timer_q    <= '0;
      drain_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      issued_q   <= '0;
    end else begin
      ras_cmd_q  <= ras_cmd_d;
      ras_args_q <= ras_args_d;
      timer_q    <= timer_d;
      drain_q    <= drain_d;
      done_q     <= done_d;
      err_q      <= err_d;
      issued_q   <= issued_d;
    end
  end

  assign ras_cmd  = ras_cmd_q;
  assign ras_args = ras_args_q;
  assign done     = done_q;
  assign err      = err_q;
  assign issued   = issued_q;
  assign busy     = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_raster_cmd_scheduler.sv
// Directed bench for raster_cmd_scheduler with a minimal rasterizer model that
// answers each sampled command with a frame_sync pulse one cycle later.
module tb_raster_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [1:0]  a_cmd, b_cmd, ras_cmd;
  logic [17:0] a_args, b_args, ras_args;
  logic        frame_sync, busy, done, err;
  logic [7:0]  issued;

  raster_cmd_scheduler #(.DEPTH(4), .SYNC_TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_cmd      (a_cmd),
    .a_args     (a_args),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_cmd      (b_cmd),
    .b_args     (b_args),
    .ras_cmd    (ras_cmd),
    .ras_args   (ras_args),
    .frame_sync (frame_sync),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .issued     (issued)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Rasterizer model: frame_sync is high the cycle after ras_cmd was sampled.
  logic ras_en;
  logic fs_pend;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_pend    <= 1'b0;
      frame_sync <= 1'b0;
    end else begin
      fs_pend    <= (ras_cmd != 2'b00);
      frame_sync <= fs_pend & ras_en;
    end
  end

  // Monitor: logs every sampled command and counts done pulses.
  int          cyc = 0;
  int          done_cnt = 0;
  logic [1:0]  iss_cmd[$];
  logic [17:0] iss_args[$];
  int          iss_cyc[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (ras_cmd != 2'b00) begin
        iss_cmd.push_back(ras_cmd);
        iss_args.push_back(ras_args);
        iss_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  logic [17:0] a_tab[4];
  logic [17:0] b_tab[3];
  logic [1:0]  exp_cmd[6];
  logic [17:0] exp_args[6];
  logic [5:0]  exp_a, exp_b;

  initial begin
    int base, done_base, n, acc_cyc, ai, bi;
    a_tab = '{18'h00111, 18'h00222, 18'h00333, 18'h00444};
    b_tab = '{18'h10001, 18'h20002, 18'h30003};
    exp_cmd  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01};
    exp_args = '{18'h00111, 18'h10001, 18'h00222, 18'h20002, 18'h00333, 18'h00444};
    exp_a = 6'b010101;  // bit c: A granted in cycle c
    exp_b = 6'b001010;

    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    a_cmd = 2'b00; b_cmd = 2'b00; a_args = '0; b_args = '0; ras_en = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ras_cmd", ras_cmd, 0);
    chk("rst_ras_args", ras_args, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_issued", issued, 0);
    rst_n = 1'b1;

    // NOP on B is handshaken and dropped
    @(negedge clk);
    base = iss_cmd.size();
    b_valid = 1'b1; b_cmd = 2'b00; b_args = 18'h3FFFF;
    #1;
    chk("nop_b_ready", b_ready, 1);
    chk("nop_a_ready", a_ready, 0);
    @(negedge clk);
    b_valid = 1'b0;
    chk("nop_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("nop_issued", issued, 0);
    chk("nop_ras_cmd", ras_cmd, 0);
    chk("nop_no_issue", iss_cmd.size() - base, 0);

    // Single command
    do_reset();
    @(negedge clk);
    base = iss_cmd.size();
    done_base = done_cnt;
    acc_cyc = cyc;
    a_valid = 1'b1; a_cmd = 2'b01; a_args = 18'h1A000;
    #1;
    chk("single_a_ready", a_ready, 1);
    @(negedge clk);
    a_valid = 1'b0;
    chk("single_pre_cmd", ras_cmd, 0);
    chk("single_busy", busy, 1);
    @(negedge clk);
    chk("single_cmd", ras_cmd, 1);
    chk("single_args", ras_args, 18'h1A000);
    chk("single_issued", issued, 1);
    @(negedge clk);
    chk("single_cmd_drop", ras_cmd, 0);
    chk("single_fs_e0", frame_sync, 0);
    @(negedge clk);
    chk("single_fs_e1", frame_sync, 1);
    @(negedge clk);
    chk("single_fs_e2", frame_sync, 0);
    n = 2;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("single_done_lat", n, 66);
    @(negedge clk);
    chk("single_done_width", done, 0);
    chk("single_busy_after", busy, 0);
    chk("single_args_held", ras_args, 18'h1A000);
    chk("single_n_issues", iss_cmd.size() - base, 1);
    chk("single_done_cnt", done_cnt - done_base, 1);
    if (iss_cmd.size() > base) begin
      chk("single_mon_cmd", iss_cmd[base], 1);
      chk("single_mon_args", iss_args[base], 18'h1A000);
      chk("single_sample_edge", iss_cyc[base] - acc_cyc, 2);
    end

    // Round-robin fill, then push into a full FIFO across a pop
    do_reset();
    base = iss_cmd.size();
    done_base = done_cnt;
    ai = 0; bi = 0;
    a_cmd = 2'b01; b_cmd = 2'b10;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a_valid = 1'b1; b_valid = 1'b1;
      a_args = a_tab[ai]; b_args = b_tab[bi];
      #1;
      chk($sformatf("rr_a_ready_%0d", c), a_ready, exp_a[c]);
      chk($sformatf("rr_b_ready_%0d", c), b_ready, exp_b[c]);
      if (a_ready && ai < 3) ai++;
      if (b_ready && bi < 2) bi++;
    end
    @(negedge clk);
    b_valid = 1'b0; a_valid = 1'b1; a_args = a_tab[3];
    #1;
    chk("pp_full_hold", a_ready, 0);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pp_done_seen", done, 1);
    chk("pp_ready_on_pop", a_ready, 0);
    @(negedge clk);
    chk("pp_ready_rise", a_ready, 1);
    @(negedge clk);
    chk("pp_refull", a_ready, 0);
    a_valid = 1'b0;
    n = 0;
    while ((iss_cmd.size() - base) < 6 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("rr_n_issues", iss_cmd.size() - base, 6);
    if (iss_cmd.size() >= base + 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("rr_order_cmd_%0d", i), iss_cmd[base+i], exp_cmd[i]);
        chk($sformatf("rr_order_args_%0d", i), iss_args[base+i], exp_args[i]);
      end
      for (int i = 1; i < 6; i++) begin
        chk($sformatf("rr_spacing_%0d", i), iss_cyc[base+i] - iss_cyc[base+i-1], 68);
      end
    end
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("rr_idle", busy, 0);
    chk("rr_issued", issued, 6);
    chk("rr_done_cnt", done_cnt - done_base, 6);

    // Watchdog with a silent rasterizer
    do_reset();
    ras_en = 1'b0;
    @(negedge clk);
    a_valid = 1'b1; a_cmd = 2'b11; a_args = 18'h0ABCD;
    @(negedge clk);
    a_cmd = 2'b10; a_args = 18'h05555;
    @(negedge clk);
    a_valid = 1'b0;
    chk("wd_first_cmd", ras_cmd, 3);
    @(negedge clk);
    n = 0;
    while (!err && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wd_err_lat", n, 8);
    @(negedge clk);
    chk("wd_next_cmd", ras_cmd, 2);
    chk("wd_next_args", ras_args, 18'h05555);
    chk("wd_issued", issued, 2);
    chk("wd_err_sticky", err, 1);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wd_idle", busy, 0);
    chk("wd_err_final", err, 1);
    ras_en = 1'b1;

    // Asynchronous reset in the middle of DRAIN
    do_reset();
    a_cmd = 2'b01;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a_valid = 1'b1; a_args = a_tab[c];
    end
    @(negedge clk);
    a_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_issued", issued, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd", ras_cmd, 0);
    chk("mid_rst_args", ras_args, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_issued", issued, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    base = iss_cmd.size();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("post_rst_no_issue", iss_cmd.size() - base, 0);
    chk("post_rst_issued", issued, 0);
    chk("post_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
